// File: rtl/bp_pkg.sv
// Shared definitions for the branch trace sequencer: sequencer states and record width.
package bp_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int REC_W          = ADDR_WIDTH_DEF + 1;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/branch_rec_fifo.sv
// Synchronous record buffer; pointers carry an extra wrap bit to tell full from empty.
module branch_rec_fifo
  import bp_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dout  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) begin
        mem[wr_ptr[PW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_trace_sequencer.sv
// Feeds buffered branch records to the perceptron predictor one at a time over its edge-triggered
// new-data handshake, and scores each prediction in saturating statistics counters.
module branch_trace_sequencer
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_taken,
  output logic [ADDR_WIDTH-1:0] bp_inst_addr,
  output logic                  bp_new_data,
  output logic                  bp_dir_truth,
  input  logic                  bp_pred_ready,
  input  logic                  bp_prediction,
  input  logic                  bp_training_done,
  input  logic                  bp_mem_rst_done,
  input  logic                  clear_stats,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  total_cnt,
  output logic [CNT_WIDTH-1:0]  mispred_cnt,
  output logic                  timeout_err
);

  localparam int RW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]        T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   timer;
  logic            pred_seen;
  logic            pred_val;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [RW-1:0]   head;
  logic            done_ok;
  logic            timed_out;
  logic            miss;

  branch_rec_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (push),
    .din   ({in_addr, in_taken}),
    .rd_en (pop),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  // Nothing is accepted until the predictor memory has been cleared.
  assign in_ready    = (state != INIT) && !full;
  assign push        = in_valid && in_ready;
  assign pop         = (state == IDLE) && !empty;
  assign bp_new_data = (state == ISSUE) || (state == WAIT);
  assign busy        = bp_new_data || (state == GAP);
  assign done_ok     = (state == WAIT) && bp_training_done;
  assign timed_out   = (state == WAIT) && !bp_training_done && (timer == T_LAST);
  // A prediction arriving together with training_done is scored directly.
  assign miss        = bp_pred_ready ? (bp_prediction != bp_dir_truth)
                                     : (!pred_seen || (pred_val != bp_dir_truth));

  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (bp_mem_rst_done) state_nx = IDLE;
      IDLE:    if (!empty) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (done_ok || timed_out) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= INIT;
      timer        <= '0;
      pred_seen    <= 1'b0;
      pred_val     <= 1'b0;
      bp_inst_addr <= '0;
      bp_dir_truth <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) begin
        {bp_inst_addr, bp_dir_truth} <= head;
        pred_seen                    <= 1'b0;
        timer                        <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 1'b1;
        if (bp_pred_ready) begin
          pred_seen <= 1'b1;
          pred_val  <= bp_prediction;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_stats) begin
      total_cnt   <= '0;
      mispred_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (done_ok) begin
        if (total_cnt != CNT_MAX) total_cnt <= total_cnt + 1'b1;
        if (miss && (mispred_cnt != CNT_MAX)) mispred_cnt <= mispred_cnt + 1'b1;
      end
      if (timed_out) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_trace_sequencer.sv
// Self-checking bench for branch_trace_sequencer: directed corner cases, a vector table and
// randomized record groups scored against a record-queue/counter reference model.
module tb_branch_trace_sequencer;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int TO    = 64;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic          in_taken;
  logic [AW-1:0] bp_inst_addr;
  logic          bp_new_data;
  logic          bp_dir_truth;
  logic          bp_pred_ready;
  logic          bp_prediction;
  logic          bp_training_done;
  logic          bp_mem_rst_done;
  logic          clear_stats;
  logic          busy;
  logic [CW-1:0] total_cnt;
  logic [CW-1:0] mispred_cnt;
  logic          timeout_err;

  always #5 clk = ~clk;

  branch_trace_sequencer #(
    .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_taken(in_taken),
    .bp_inst_addr(bp_inst_addr), .bp_new_data(bp_new_data), .bp_dir_truth(bp_dir_truth),
    .bp_pred_ready(bp_pred_ready), .bp_prediction(bp_prediction),
    .bp_training_done(bp_training_done), .bp_mem_rst_done(bp_mem_rst_done),
    .clear_stats(clear_stats), .busy(busy),
    .total_cnt(total_cnt), .mispred_cnt(mispred_cnt), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          taken;
  } rec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          taken;
    int            pr;
    int            td;
    logic          pred;
    int            exp_tot;
    int            exp_mis;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t q[$];
  int   m_tot = 0;
  int   m_mis = 0;
  bit   m_err = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic t, input int limit, output bit ok);
    ok       = 1'b0;
    in_addr  = a;
    in_taken = t;
    in_valid = 1'b1;
    for (int k = 0; k < limit && !ok; k++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (ok) q.push_back('{a, t});
  endtask

  // Predictor stand-in: pred_ready at cycle pr after the rising edge, training_done at td
  // (0 = never). exp_wait is the expected number of cycles until the edge (0 = unchecked).
  task automatic serve(input int pr, input int td, input logic pred, input bit clr,
                       input int exp_wait);
    int            w;
    int            cyc;
    bit            fell;
    bit            stable;
    bit            seen;
    bit            mis;
    rec_t          e;
    logic [AW-1:0] a0;
    logic          t0;
    w = 0;
    while (bp_new_data !== 1'b1 && w < 60) begin
      tick();
      w++;
    end
    if (bp_new_data !== 1'b1) begin
      chk("issue_edge", bp_new_data, 1);
      return;
    end
    if (exp_wait > 0) chk("issue_latency", w, exp_wait);
    if (q.size() == 0) begin
      chk("spurious_issue", bp_new_data, 0);
      return;
    end
    e = q.pop_front();
    chk("issue_addr", bp_inst_addr, e.addr);
    chk("issue_truth", bp_dir_truth, e.taken);
    chk("busy_issue", busy, 1);
    a0 = bp_inst_addr;
    t0 = bp_dir_truth;
    stable = 1'b1;
    cyc = 0;
    fell = 1'b0;
    bp_prediction = pred;
    while (!fell && cyc < TO + 10) begin
      tick();
      cyc++;
      if (!bp_new_data) begin
        fell = 1'b1;
      end else begin
        if (bp_inst_addr !== a0 || bp_dir_truth !== t0) stable = 1'b0;
      end
      bp_pred_ready    = !fell && (cyc == pr);
      bp_training_done = !fell && (cyc == td);
      clear_stats      = !fell && clr && (cyc == td);
    end
    bp_pred_ready    = 1'b0;
    bp_training_done = 1'b0;
    clear_stats      = 1'b0;
    chk("hold_stable", stable, 1);
    chk("release_cycle", cyc, (td > 0) ? td + 1 : TO + 1);
    if (td > 0) begin
      seen = (pr > 0) && (pr <= td);
      mis  = !seen || (pred != e.taken);
      if (clr) begin
        m_tot = 0;
        m_mis = 0;
        m_err = 1'b0;
      end else begin
        if (m_tot < CMAX) m_tot++;
        if (mis && m_mis < CMAX) m_mis++;
      end
    end else begin
      m_err = 1'b1;
    end
    chk("total_cnt", total_cnt, m_tot);
    chk("mispred_cnt", mispred_cnt, m_mis);
    chk("timeout_err", timeout_err, m_err);
    chk("busy_gap", busy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t          vecs[6];
    bit            ok;
    bit            ok2;
    bit            okr;
    bit            hold_ok;
    int            acc;
    int            n;
    int            rpr;
    int            rtd;
    bit            rclr;
    logic          rpred;
    logic [AW-1:0] ra;
    logic          rt;

    vecs[0] = '{8'h01, 1'b1, 4, 4, 1'b1, 1, 0};
    vecs[1] = '{8'h02, 1'b0, 3, 9, 1'b1, 2, 1};
    vecs[2] = '{8'h03, 1'b0, 0, 5, 1'b0, 3, 2};
    vecs[3] = '{8'h04, 1'b1, 8, 6, 1'b1, 4, 3};
    vecs[4] = '{8'hFF, 1'b0, 1, 1, 1'b0, 5, 3};
    vecs[5] = '{8'h80, 1'b1, 2, 30, 1'b1, 6, 3};

    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_taken = 1'b0;
    bp_pred_ready = 1'b0; bp_prediction = 1'b0; bp_training_done = 1'b0;
    bp_mem_rst_done = 1'b0; clear_stats = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_new_data", bp_new_data, 0);
    chk("rst_inst_addr", bp_inst_addr, 0);
    chk("rst_dir_truth", bp_dir_truth, 0);
    chk("rst_busy", busy, 0);
    chk("rst_total", total_cnt, 0);
    chk("rst_mispred", mispred_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // Record offered before the predictor memory clear: nothing accepted or issued.
    in_addr = 8'h14; in_taken = 1'b1; in_valid = 1'b1;
    hold_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (in_ready || bp_new_data) hold_ok = 1'b0;
      tick();
    end
    chk("init_holds_off", hold_ok, 1);
    bp_mem_rst_done = 1'b1;
    tick();
    bp_mem_rst_done = 1'b0;
    push(8'h14, 1'b1, 10, ok);
    chk("first_push", ok, 1);
    serve(10, 10, 1'b1, 1'b0, 1);

    push(8'h5A, 1'b1, 10, ok);
    serve(10, 28, 1'b0, 1'b0, 1);

    // Stall the predictor and overfill the buffer.
    push(8'h21, 1'b0, 10, ok);
    fork
      serve(5, 40, 1'b0, 1'b0, 1);
      begin
        acc = 0;
        repeat (4) tick();
        for (int k = 0; k < 6; k++) begin
          push(8'(8'h30 + k), k[0], 3, ok2);
          if (ok2) acc++;
        end
        chk("fifo_accepts", acc, DEPTH);
        chk("in_ready_full", in_ready, 0);
      end
    join
    for (int k = 0; k < DEPTH; k++) serve(k + 1, k + 3, 1'b1, 1'b0, 2);

    push(8'h77, 1'b1, 10, ok);
    serve(3, 0, 1'b1, 1'b0, 1);
    push(8'h78, 1'b0, 10, ok);
    serve(2, 4, 1'b0, 1'b0, 1);
    push(8'h79, 1'b1, 10, ok);
    serve(2, 2, 1'b0, 1'b1, 1);

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].addr, vecs[i].taken, 10, ok);
      serve(vecs[i].pr, vecs[i].td, vecs[i].pred, 1'b0, 1);
      chk("vec_total", total_cnt, vecs[i].exp_tot);
      chk("vec_mispred", mispred_cnt, vecs[i].exp_mis);
    end

    for (int g = 0; g < 170; g++) begin
      n = $urandom_range(1, 3);
      ra = 8'($urandom);
      rt = 1'($urandom);
      push(ra, rt, 20, ok);
      fork
        begin
          for (int j = 0; j < n; j++) begin
            rtd   = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 25);
            rpr   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 26);
            rpred = 1'($urandom);
            rclr  = (g < 15) && (rtd > 0) && ($urandom_range(0, 29) == 0);
            serve(rpr, rtd, rpred, rclr, (j == 0) ? 1 : ((q.size() > 0) ? 2 : 0));
          end
        end
        begin
          for (int j = 1; j < n; j++) push(8'($urandom), 1'($urandom), 20, okr);
        end
      join
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
